noc_inject_arb: RTL
===================

Name: noc_inject_arb

Overview:
Round-robin injection arbiter that lets NumSrc local traffic sources share one HNoC PE injection port (i_pe_dataN / i_pe_data_validN / o_pe_data_readyN).
- Enforces a per-source packet quota.
- Registers the winning packet in a single-entry output stage.
- Reports delivered-packet count and a sticky done flag, for throughput runs in the clk100 PE domain.

Parameters:
NumSrc, 4, number of requesting sources (2..8)
DataWidth, 32, payload width
AddrWidth, 3, destination address width; packet = {dest, payload}, TotalWidth = DataWidth+AddrWidth
PktLimit, 100, packets each source may inject before it is masked; 0 = unlimited

Ports:
clk  in  1  PE-domain clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous clear of counters, pointer and done; output register untouched
i_src_data  in  NumSrc*TotalWidth  flattened source packets, source k at [k*TotalWidth +: TotalWidth]
i_src_valid  in  NumSrc  per-source valid
o_src_ready  out  NumSrc  per-source ready, at most one bit high
o_noc_data  out  TotalWidth  packet to NoC injection port
o_noc_valid  out  1  packet valid
i_noc_ready  in  1  NoC injection ready
o_total_pkts  out  32  packets delivered to NoC (o_noc_valid && i_noc_ready)
o_done  out  1  sticky: all quotas met and output stage empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - o_noc_valid=0, o_noc_data=0, o_src_ready=0, o_total_pkts=0, o_done=0.
  - Per-source counters=0; rr pointer=0.
- Eligibility: elig[k] = i_src_valid[k] && (PktLimit==0 || cnt[k] < PktLimit).
- Load enable: load = !o_noc_valid || i_noc_ready.
- Grant:
  - Only when load is high: one-hot grant to the first eligible source searching from ptr upward, wrapping NumSrc-1 -> 0.
  - o_src_ready = grant; combinational from i_src_valid. Sources must not derive valid from ready.
- Transfer on edge with grant[k]=1:
  - o_noc_data <= source k data; o_noc_valid <= 1.
  - cnt[k] increments, saturating at PktLimit.
  - ptr <= (k+1) mod NumSrc.
- Drain: load high with no grant and i_noc_ready → o_noc_valid <= 0. o_noc_data holds its last value.
- Stall: o_noc_valid && !i_noc_ready → o_noc_data and o_noc_valid stable, o_src_ready=0, ptr unchanged.
- Latency and throughput: 1 cycle source acceptance to o_noc_valid. Sustained 1 packet/cycle when i_noc_ready stays high (simultaneous drain and load).
- Fairness: with all NumSrc sources continuously valid, grants follow 0,1,..,NumSrc-1,0,…; no source waits more than NumSrc-1 grants.
- o_total_pkts: +1 per delivered packet; wraps at 2^32.
- o_done:
  - Set the cycle after all cnt[k]==PktLimit and o_noc_valid==0.
  - Stays set until reset or i_clear.
  - Never set if PktLimit==0.
- i_clear:
  - Zeroes cnt[], ptr, o_total_pkts, o_done.
  - If coincident with a grant or delivery, clear wins: the counters read 0, the packet is still loaded/delivered, and ptr=0.
- Asynchronous reset mid-packet discards the output register contents; no partial state survives.

Decomposition:
- Shared package noc_pkg:
  - TotalWidth computation.
  - Helper functions: dest field extract {data[TotalWidth-1 -: AddrWidth]}, payload extract.
  - Delivered-packet counter width constant (32).
- Sub-module rr_arbiter (parameter N):
  - Purely combinational.
  - Inputs: req[N], ptr[$clog2(N)], en.
  - Outputs: one-hot gnt[N] and encoded gnt_idx.
  - Reused by any future NoC-side arbiter.
- noc_inject_arb holds the output register, counters, pointer and done logic.

Test Plan:
- Reset release, all i_src_valid=4'b1111, i_noc_ready=1 → grants 0,1,2,3,0… one per cycle; o_noc_valid high from cycle 1; o_total_pkts=8 after 8 cycles.
- Only source 2 valid, i_noc_ready=0 for 5 cycles after first load → o_noc_data frozen to source 2 packet, o_src_ready=0 throughout. Ready restored → next source 2 packet loads the same edge the first drains.
- PktLimit=3, all sources valid, ready=1 → each source granted exactly 3 times; o_total_pkts=12; o_done=1 one cycle after the output stage empties; o_src_ready stays 0 afterwards.
- Sources 1 and 3 valid, ptr=2 → source 3 granted first, then 1, alternating.
- i_clear asserted on the same edge as a delivery with cnt=(5,5,5,5) → counters 0, o_total_pkts=0, packet still delivered, o_done=0, next grant goes to source 0.
- rst_n pulsed low mid-stall with o_noc_valid=1 → o_noc_valid=0 and o_noc_data=0 immediately (asynchronous); after release the same behaviour as the first scenario.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: packet width arithmetic, field helpers and
// the delivered-packet counter width.
package noc_pkg;

    localparam int PktCntWidth   = 32;
    localparam int DefDataWidth  = 32;
    localparam int DefAddrWidth  = 3;
    localparam int DefTotalWidth = DefDataWidth + DefAddrWidth;

    function automatic int total_width(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic logic [DefAddrWidth-1:0] pkt_dest(input logic [DefTotalWidth-1:0] pkt);
        return pkt[DefTotalWidth-1 -: DefAddrWidth];
    endfunction

    function automatic logic [DefDataWidth-1:0] pkt_payload(input logic [DefTotalWidth-1:0] pkt);
        return pkt[DefDataWidth-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping from N-1 back to 0. Grant is one-hot plus its encoded index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [PtrW-1:0] gnt_idx
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PtrW'(idx);
            end
        end
    end

endmodule

// File: rtl/noc_inject_arb.sv
// Round-robin injection arbiter sharing one PE injection port among NumSrc
// sources, with per-source quota, single-entry output stage and done flag.
module noc_inject_arb
    import noc_pkg::*;
#(
    parameter int NumSrc    = 4,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 3,
    parameter int PktLimit  = 100,
    localparam int TotalWidth = total_width(DataWidth, AddrWidth)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic [NumSrc*TotalWidth-1:0] i_src_data,
    input  logic [NumSrc-1:0]            i_src_valid,
    output logic [NumSrc-1:0]            o_src_ready,
    output logic [TotalWidth-1:0]        o_noc_data,
    output logic                         o_noc_valid,
    input  logic                         i_noc_ready,
    output logic [PktCntWidth-1:0]       o_total_pkts,
    output logic                         o_done
);

    localparam int PtrW = $clog2(NumSrc);
    localparam int CntW = (PktLimit == 0) ? 1 : $clog2(PktLimit + 1);
    localparam logic [CntW-1:0] Limit = CntW'(PktLimit);

    logic [CntW-1:0]        cnt_q [NumSrc];
    logic [CntW-1:0]        cnt_d [NumSrc];
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [TotalWidth-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic [PktCntWidth-1:0] total_q, total_d;
    logic                   done_q, done_d;

    logic [NumSrc-1:0]      elig;
    logic [NumSrc-1:0]      gnt;
    logic [PtrW-1:0]        gnt_idx;
    logic                   load;
    logic                   arb_en;
    logic                   all_met;

    always_comb begin
        elig    = '0;
        all_met = 1'b1;
        for (int unsigned k = 0; k < NumSrc; k++) begin
            elig[k] = i_src_valid[k] && (PktLimit == 0 || cnt_q[k] < Limit);
            if (cnt_q[k] != Limit) all_met = 1'b0;
        end
    end

    assign load   = !valid_q || i_noc_ready;
    // Gating with rst_n keeps o_src_ready low while reset is held.
    assign arb_en = load && rst_n;

    rr_arbiter #(.N(NumSrc)) u_arb (
        .req     (elig),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        done_d  = done_q;

        if (|gnt) begin
            data_d  = i_src_data[int'(gnt_idx)*TotalWidth +: TotalWidth];
            valid_d = 1'b1;
            if (PktLimit != 0) cnt_d[gnt_idx] = cnt_q[gnt_idx] + 1'b1;
            ptr_d   = (int'(gnt_idx) == NumSrc - 1) ? '0 : gnt_idx + 1'b1;
        end else if (i_noc_ready) begin
            valid_d = 1'b0;
        end

        if (valid_q && i_noc_ready) total_d = total_q + 1'b1;
        if (PktLimit != 0 && all_met && !valid_q) done_d = 1'b1;

        // Clear overrides bookkeeping only; the packet transfer above still happens.
        if (i_clear) begin
            for (int unsigned k = 0; k < NumSrc; k++) cnt_d[k] = '0;
            ptr_d   = '0;
            total_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NumSrc; k++) cnt_q[k] <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            total_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            total_q <= total_d;
            done_q  <= done_d;
        end
    end

    assign o_src_ready  = gnt;
    assign o_noc_data   = data_q;
    assign o_noc_valid  = valid_q;
    assign o_total_pkts = total_q;
    assign o_done       = done_q;

endmodule
